// File: rtl/eu_writeback_queue.sv
// Result write-back queue: buffers ALU results with status and destination
// address, drains them to memory in issue order over a valid/ack handshake,
// and keeps a masked flag register updated on every accepted push.
// Optional feature: define WB_ADDR_LOG_EN to keep a shift log of written addresses.
module eu_writeback_queue #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned STATUS_W  = 16,
    parameter int unsigned DEPTH     = 8,
    parameter logic [STATUS_W-1:0] FLAG_MASK = 16'h0FD5,
    parameter int unsigned LOG_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_result,
    input  logic [STATUS_W-1:0]         in_status,
    input  logic [ADDR_W-1:0]           in_addr,
    input  logic                        in_word,
    output logic                        mem_wr_en,
    input  logic                        mem_ack,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_data,
    output logic [DATA_W/8-1:0]         mem_be,
    output logic [STATUS_W-1:0]         flag_out,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        ovf,
    output logic [LOG_DEPTH*ADDR_W-1:0] used_addr
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned BeW  = DATA_W / 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              word;
    } entry_t;

    typedef enum logic [0:0] {StIdle, StWrite} state_t;

    entry_t              entry_d [DEPTH];
    entry_t              entry_q [DEPTH];
    logic [PtrW-1:0]     wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q, rd_nxt;
    logic [CntW-1:0]     count_d, count_q;
    state_t              state_d, state_q;
    logic                wr_en_d, wr_en_q;
    logic [ADDR_W-1:0]   addr_d, addr_q;
    logic [DATA_W-1:0]   data_d, data_q;
    logic [BeW-1:0]      be_d, be_q;
    logic [STATUS_W-1:0] flag_d, flag_q;
    logic                ovf_d, ovf_q;
    logic                push, pop;
    entry_t              in_entry, head, next_entry;

    function automatic logic [BeW-1:0] be_of(input logic word);
        return word ? {BeW{1'b1}} : BeW'(1);
    endfunction

    assign in_ready  = (count_q < CntW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign pop       = (state_q == StWrite) && mem_ack;
    assign in_entry  = {in_addr, in_result, in_word};
    assign rd_nxt    = rd_ptr_q + PtrW'(1);
    assign head      = entry_q[rd_ptr_q];
    // With one entry left, the follow-on entry can only be the one arriving this edge.
    assign next_entry = (count_q > CntW'(1)) ? entry_q[rd_nxt] : in_entry;

    // Queue storage, pointers, flags and the write-out FSM next state.
    always_comb begin
        entry_d  = entry_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        wr_en_d  = wr_en_q;
        addr_d   = addr_q;
        data_d   = data_q;
        be_d     = be_q;
        flag_d   = flag_q;
        ovf_d    = ovf_q || (in_valid && !in_ready);

        if (push) begin
            entry_d[wr_ptr_q] = in_entry;
            wr_ptr_d          = wr_ptr_q + PtrW'(1);
            flag_d            = (flag_q & ~FLAG_MASK) | (in_status & FLAG_MASK);
        end
        if (pop) begin
            rd_ptr_d = rd_nxt;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    addr_d  = head.addr;
                    data_d  = head.data;
                    be_d    = be_of(head.word);
                    wr_en_d = 1'b1;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (mem_ack) begin
                    if (count_d != '0) begin
                        addr_d = next_entry.addr;
                        data_d = next_entry.data;
                        be_d   = be_of(next_entry.word);
                    end else begin
                        wr_en_d = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= StIdle;
            wr_en_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            be_q     <= '0;
            flag_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            wr_en_q  <= wr_en_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            be_q     <= be_d;
            flag_q   <= flag_d;
            ovf_q    <= ovf_d;
        end
    end

    // Entry payload storage; contents are don't-care while unoccupied, so no reset.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    assign mem_wr_en = wr_en_q;
    assign mem_addr  = addr_q;
    assign mem_data  = data_q;
    assign mem_be    = be_q;
    assign flag_out  = flag_q;
    assign count     = count_q;
    assign ovf       = ovf_q;

`ifdef WB_ADDR_LOG_EN
    logic [LOG_DEPTH*ADDR_W-1:0] log_d, log_q;

    // Shift the address of each acknowledged write into slot 0.
    always_comb begin
        log_d = log_q;
        if (pop) begin
            log_d = {log_q[(LOG_DEPTH-1)*ADDR_W-1:0], addr_q};
        end
    end

    // Address log register.
    always_ff @(posedge clk) begin
        if (reset) begin
            log_q <= '0;
        end else begin
            log_q <= log_d;
        end
    end

    assign used_addr = log_q;
`else
    assign used_addr = '0;
`endif

endmodule

// File: tb/tb_eu_writeback_queue.sv
// Self-checking bench for eu_writeback_queue: directed vector table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_eu_writeback_queue;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 20;
    localparam int STATUS_W  = 16;
    localparam int DEPTH     = 8;
    localparam int LOG_DEPTH = 16;
    localparam int BEW       = DATA_W / 8;
    localparam logic [STATUS_W-1:0] MASK = 16'h0FD5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        reset, in_valid, in_ready, in_word, mem_wr_en, mem_ack, ovf;
    logic [DATA_W-1:0]           in_result, mem_data;
    logic [STATUS_W-1:0]         in_status, flag_out;
    logic [ADDR_W-1:0]           in_addr, mem_addr;
    logic [BEW-1:0]              mem_be;
    logic [$clog2(DEPTH):0]      count;
    logic [LOG_DEPTH*ADDR_W-1:0] used_addr;

    eu_writeback_queue dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_status(in_status), .in_addr(in_addr), .in_word(in_word),
        .mem_wr_en(mem_wr_en), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_be(mem_be), .flag_out(flag_out), .count(count), .ovf(ovf), .used_addr(used_addr)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue holds every accepted entry; its front is what memory sees.
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              word;
    } ent_t;

    ent_t                        mq[$];
    logic                        m_wr_en;
    logic [ADDR_W-1:0]           m_addr;
    logic [DATA_W-1:0]           m_data;
    logic [BEW-1:0]              m_be;
    logic [STATUS_W-1:0]         m_flag;
    logic                        m_ovf;
    logic [ADDR_W-1:0]           m_log[$];

    task automatic load_front();
        m_addr = mq[0].addr;
        m_data = mq[0].data;
        m_be   = mq[0].word ? {BEW{1'b1}} : BEW'(1);
    endtask

    task automatic model_step();
        bit   acc;
        ent_t e;
        if (reset) begin
            mq.delete();
            m_wr_en = 0; m_addr = '0; m_data = '0; m_be = '0; m_flag = '0; m_ovf = 0;
            m_log.delete();
            return;
        end
        acc = in_valid && (mq.size() < DEPTH);
        if (in_valid && !acc) m_ovf = 1;
        if (acc) m_flag = (m_flag & ~MASK) | (in_status & MASK);
        e.addr = in_addr; e.data = in_result; e.word = in_word;
        if (!m_wr_en) begin
            if (mq.size() > 0) begin
                load_front();
                m_wr_en = 1;
            end
            if (acc) mq.push_back(e);
        end else if (mem_ack) begin
            m_log.push_front(m_addr);
            if (m_log.size() > LOG_DEPTH) void'(m_log.pop_back());
            void'(mq.pop_front());
            if (acc) mq.push_back(e);
            if (mq.size() > 0) load_front();
            else m_wr_en = 0;
        end else if (acc) begin
            mq.push_back(e);
        end
    endtask

    function automatic logic [LOG_DEPTH*ADDR_W-1:0] model_log();
        logic [LOG_DEPTH*ADDR_W-1:0] v = '0;
`ifdef WB_ADDR_LOG_EN
        for (int j = 0; j < m_log.size(); j++) v[j*ADDR_W +: ADDR_W] = m_log[j];
`endif
        return v;
    endfunction

    // Drive one cycle of inputs, advance model on the edge, compare just after it.
    task automatic cycle(input logic r, input logic v, input logic [DATA_W-1:0] res,
                         input logic [STATUS_W-1:0] st, input logic [ADDR_W-1:0] a,
                         input logic w, input logic ack);
        reset = r; in_valid = v; in_result = res; in_status = st; in_addr = a;
        in_word = w; mem_ack = ack;
        @(posedge clk);
        model_step();
        #1;
        chk("mem_wr_en", 64'(mem_wr_en), 64'(m_wr_en));
        chk("mem_addr",  64'(mem_addr),  64'(m_addr));
        chk("mem_data",  64'(mem_data),  64'(m_data));
        chk("mem_be",    64'(mem_be),    64'(m_be));
        chk("flag_out",  64'(flag_out),  64'(m_flag));
        chk("count",     64'(count),     64'(mq.size()));
        chk("in_ready",  64'(in_ready),  64'(mq.size() < DEPTH));
        chk("ovf",       64'(ovf),       64'(m_ovf));
        n_chk++;
        if (used_addr !== model_log()) begin
            n_fail++;
            $display("FAIL used_addr: got %0h expected %0h", used_addr, model_log());
        end
    endtask

    typedef struct {
        logic r, v; logic [15:0] res, st; logic [19:0] a; logic w, ack;
        logic e_wr; logic [19:0] e_addr; logic [15:0] e_data; logic [1:0] e_be;
        logic [3:0] e_cnt; logic [15:0] e_flag;
    } vec_t;

    vec_t vt[11];

    initial begin
        //        r  v  res      st       addr      w  ack  wr addr      data     be     cnt flag
        vt[0]  = '{1, 0, 16'h0,    16'h0,    20'h0,    0, 0, 0, 20'h0,    16'h0,    2'b00, 0, 16'h0};
        vt[1]  = '{0, 1, 16'h1234, 16'h0,    20'h00020, 1, 1, 0, 20'h0,    16'h0,    2'b00, 1, 16'h0};
        vt[2]  = '{0, 0, 16'h0,    16'h0,    20'h0,    0, 1, 1, 20'h00020, 16'h1234, 2'b11, 1, 16'h0};
        vt[3]  = '{0, 0, 16'h0,    16'h0,    20'h0,    0, 1, 0, 20'h00020, 16'h1234, 2'b11, 0, 16'h0};
        vt[4]  = '{0, 1, 16'h0003, 16'h0040, 20'h00021, 0, 0, 0, 20'h00020, 16'h1234, 2'b11, 1, 16'h0040};
        vt[5]  = '{0, 0, 16'h0,    16'h0,    20'h0,    0, 0, 1, 20'h00021, 16'h0003, 2'b01, 1, 16'h0040};
        vt[6]  = '{0, 0, 16'h0,    16'h0,    20'h0,    0, 0, 1, 20'h00021, 16'h0003, 2'b01, 1, 16'h0040};
        vt[7]  = '{0, 0, 16'h0,    16'h0,    20'h0,    0, 1, 0, 20'h00021, 16'h0003, 2'b01, 0, 16'h0040};
        vt[8]  = '{0, 1, 16'hAAAA, 16'hF02A, 20'h00030, 1, 0, 0, 20'h00021, 16'h0003, 2'b01, 1, 16'h0000};
        vt[9]  = '{0, 0, 16'h0,    16'h0,    20'h0,    0, 0, 1, 20'h00030, 16'hAAAA, 2'b11, 1, 16'h0000};
        vt[10] = '{1, 0, 16'h0,    16'h0,    20'h0,    0, 0, 0, 20'h0,    16'h0,    2'b00, 0, 16'h0};

        m_wr_en = 0; m_addr = '0; m_data = '0; m_be = '0; m_flag = '0; m_ovf = 0;
        reset = 1; in_valid = 0; in_result = '0; in_status = '0; in_addr = '0;
        in_word = 0; mem_ack = 0;

        // Directed vector table.
        for (int i = 0; i < 11; i++) begin
            cycle(vt[i].r, vt[i].v, vt[i].res, vt[i].st, vt[i].a, vt[i].w, vt[i].ack);
            chk($sformatf("vec%0d.wr_en", i), 64'(mem_wr_en), 64'(vt[i].e_wr));
            chk($sformatf("vec%0d.addr", i),  64'(mem_addr),  64'(vt[i].e_addr));
            chk($sformatf("vec%0d.data", i),  64'(mem_data),  64'(vt[i].e_data));
            chk($sformatf("vec%0d.be", i),    64'(mem_be),    64'(vt[i].e_be));
            chk($sformatf("vec%0d.count", i), 64'(count),     64'(vt[i].e_cnt));
            chk($sformatf("vec%0d.flag", i),  64'(flag_out),  64'(vt[i].e_flag));
        end

        // Fill to full with memory stalled, then overflow, then drain back-to-back.
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++)
            cycle(0, 1, 16'(16'h5000 + i), 16'h0, 20'(20'h100 + i), 1, 0);
        chk("full.count", 64'(count), 64'(DEPTH));
        chk("full.in_ready", 64'(in_ready), 64'(0));
        chk("full.ovf_clear", 64'(ovf), 64'(0));
        cycle(0, 1, 16'hDEAD, 16'h0, 20'h1FF, 1, 0);
        chk("ovf.set", 64'(ovf), 64'(1));
        chk("ovf.count", 64'(count), 64'(DEPTH));
        for (int k = 1; k <= DEPTH; k++) begin
            cycle(0, 0, 0, 0, 0, 0, 1);
            if (k < DEPTH) begin
                chk($sformatf("drain%0d.wr_en", k), 64'(mem_wr_en), 64'(1));
                chk($sformatf("drain%0d.addr", k), 64'(mem_addr), 64'(20'h100 + k));
            end else begin
                chk("drain.idle", 64'(mem_wr_en), 64'(0));
                chk("drain.count", 64'(count), 64'(0));
            end
        end
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("ovf.sticky", 64'(ovf), 64'(1));

`ifdef WB_ADDR_LOG_EN
        cycle(1, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 3; i++) cycle(0, 1, 16'(i), 16'h0, 20'(i), 1, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 1);
        chk("log.slot0", 64'(used_addr[0 +: ADDR_W]), 64'(3));
        chk("log.slot1", 64'(used_addr[ADDR_W +: ADDR_W]), 64'(2));
        chk("log.slot2", 64'(used_addr[2*ADDR_W +: ADDR_W]), 64'(1));
`else
        chk("log.tied_off", 64'(used_addr[63:0]), 64'(0));
`endif

        // Randomized traffic against the model.
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 6),
                  16'($urandom), 16'($urandom), 20'($urandom), 1'($urandom),
                  ($urandom_range(0, 9) < (i < 400 ? 3 : 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
